// File: rtl/tt_rng_collector.sv
// Random bit collector: health tests (RCT/APT), warm-up discard,
// MSB-first word packing and a small valid/ready output FIFO.
module tt_rng_collector #(
    parameter int unsigned WORD_W     = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned WARMUP     = 64,
    parameter int unsigned RCT_CUTOFF = 32,
    parameter int unsigned APT_WINDOW = 512,
    parameter int unsigned APT_CUTOFF = 410
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            enable,
    input  logic                            clr,
    input  logic                            bit_in,
    input  logic                            bit_valid,
    output logic [WORD_W-1:0]               out_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic                            health_fail,
    output logic [1:0]                      fail_code,
    output logic                            overflow,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic [1:0]                      state
);

    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned RC_W  = $clog2(RCT_CUTOFF + 1);
    localparam int unsigned AP_W  = $clog2(APT_WINDOW + 1);
    localparam int unsigned WU_W  = $clog2(WARMUP + 1);
    localparam int unsigned BC_W  = $clog2(WORD_W + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_WARM = 2'b01,
        S_RUN  = 2'b10,
        S_FAIL = 2'b11
    } state_t;

    state_t              state_q, state_n;
    logic [RC_W-1:0]     rc_q, rc_n;
    logic                prev_q, prev_n;
    logic [AP_W-1:0]     apt_pos_q, apt_pos_n;
    logic [AP_W-1:0]     ac_q, ac_n;
    logic                ref_q, ref_n;
    logic [WU_W-1:0]     warm_q, warm_n;
    logic [BC_W-1:0]     bit_cnt_q, bit_cnt_n;
    logic [WORD_W-2:0]   shreg_q, shreg_n;
    logic [WORD_W-1:0]   mem_q [FIFO_DEPTH];
    logic [WORD_W-1:0]   mem_n [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_q, wr_n, rd_q, rd_n;
    logic [LVL_W-1:0]    level_n;
    logic [WORD_W-1:0]   out_data_n;
    logic                out_valid_n, health_fail_n, overflow_n;
    logic [1:0]          fail_code_n;

    logic                accept, rd_en, wr_en, do_wr, full, flush, rct_hit, apt_hit;
    logic [WORD_W-1:0]   word;

    assign state = state_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_n;
    end

    // Next state, health tests, packing and FIFO bookkeeping
    always_comb begin
        state_n       = state_q;
        rc_n          = rc_q;
        prev_n        = prev_q;
        apt_pos_n     = apt_pos_q;
        ac_n          = ac_q;
        ref_n         = ref_q;
        warm_n        = warm_q;
        bit_cnt_n     = bit_cnt_q;
        shreg_n       = shreg_q;
        mem_n         = mem_q;
        wr_n          = wr_q;
        rd_n          = rd_q;
        level_n       = fifo_level;
        health_fail_n = health_fail;
        fail_code_n   = fail_code;
        overflow_n    = overflow;
        accept        = bit_valid && (state_q == S_WARM || state_q == S_RUN);
        rd_en         = out_valid && out_ready;
        wr_en         = 1'b0;
        do_wr         = 1'b0;
        full          = (fifo_level == LVL_W'(FIFO_DEPTH));
        flush         = 1'b0;
        rct_hit       = 1'b0;
        apt_hit       = 1'b0;
        word          = {shreg_q, bit_in};

        case (state_q)
            S_IDLE: begin
                rc_n      = '0;
                prev_n    = 1'b0;
                apt_pos_n = '0;
                ac_n      = '0;
                ref_n     = 1'b0;
                warm_n    = '0;
                bit_cnt_n = '0;
                shreg_n   = '0;
                if (clr)    overflow_n = 1'b0;
                if (enable) state_n = S_WARM;
            end
            S_WARM, S_RUN: begin
                if (clr)     overflow_n = 1'b0;
                if (!enable) state_n = S_IDLE;
            end
            default: begin
                if (clr) begin
                    state_n       = S_IDLE;
                    health_fail_n = 1'b0;
                    fail_code_n   = 2'b00;
                    overflow_n    = 1'b0;
                end
            end
        endcase

        if (accept) begin
            rc_n   = (rc_q == '0 || bit_in != prev_q) ? RC_W'(1) : rc_q + RC_W'(1);
            prev_n = bit_in;
            if (apt_pos_q == '0 || apt_pos_q == AP_W'(APT_WINDOW)) begin
                ref_n     = bit_in;
                ac_n      = AP_W'(1);
                apt_pos_n = AP_W'(1);
            end else begin
                apt_pos_n = apt_pos_q + AP_W'(1);
                ac_n      = (bit_in == ref_q) ? ac_q + AP_W'(1) : ac_q;
            end
            rct_hit = (rc_n == RC_W'(RCT_CUTOFF));
            apt_hit = (ac_n == AP_W'(APT_CUTOFF));

            if (rct_hit || apt_hit) begin
                state_n       = S_FAIL;
                health_fail_n = 1'b1;
                fail_code_n   = {apt_hit, rct_hit};
                flush         = 1'b1;
            end else if (state_q == S_WARM) begin
                warm_n = warm_q + WU_W'(1);
                if (enable && warm_n == WU_W'(WARMUP)) state_n = S_RUN;
            end else begin
                shreg_n = word[WORD_W-2:0];
                if (bit_cnt_q == BC_W'(WORD_W - 1)) begin
                    bit_cnt_n = '0;
                    wr_en     = 1'b1;
                end else begin
                    bit_cnt_n = bit_cnt_q + BC_W'(1);
                end
            end
        end

        if (flush) begin
            wr_n    = '0;
            rd_n    = '0;
            level_n = '0;
        end else begin
            do_wr = wr_en && (!full || rd_en);
            if (wr_en && !do_wr) overflow_n = 1'b1;
            if (do_wr) begin
                mem_n[wr_q] = word;
                wr_n        = wr_q + PTR_W'(1);
            end
            if (rd_en) rd_n = rd_q + PTR_W'(1);
            if (do_wr && !rd_en)      level_n = fifo_level + LVL_W'(1);
            else if (!do_wr && rd_en) level_n = fifo_level - LVL_W'(1);
        end

        out_valid_n = (level_n != '0);
        out_data_n  = mem_n[rd_n];
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rc_q        <= '0;
            prev_q      <= 1'b0;
            apt_pos_q   <= '0;
            ac_q        <= '0;
            ref_q       <= 1'b0;
            warm_q      <= '0;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
            wr_q        <= '0;
            rd_q        <= '0;
            fifo_level  <= '0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            health_fail <= 1'b0;
            fail_code   <= 2'b00;
            overflow    <= 1'b0;
        end else begin
            rc_q        <= rc_n;
            prev_q      <= prev_n;
            apt_pos_q   <= apt_pos_n;
            ac_q        <= ac_n;
            ref_q       <= ref_n;
            warm_q      <= warm_n;
            bit_cnt_q   <= bit_cnt_n;
            shreg_q     <= shreg_n;
            mem_q       <= mem_n;
            wr_q        <= wr_n;
            rd_q        <= rd_n;
            fifo_level  <= level_n;
            out_data    <= out_data_n;
            out_valid   <= out_valid_n;
            health_fail <= health_fail_n;
            fail_code   <= fail_code_n;
            overflow    <= overflow_n;
        end
    end

endmodule
